// File: rtl/serdes_tx_sched.sv
// Transmit-side scheduler for a shared parallel-to-serial shifter.
// Round-robin arbitration among N requesters, one word per BITS-clock slot,
// comma words for link alignment after reset/resume, idle words when nobody has data.
module serdes_tx_sched #(
    parameter int unsigned     N          = 4,
    parameter int unsigned     BITS       = 8,
    parameter int unsigned     SYNC_WORDS = 4,
    parameter logic [BITS-1:0] COMMA      = BITS'(8'hBC),
    parameter logic [BITS-1:0] IDLE_WORD  = BITS'(8'h1C),
    parameter int unsigned     IDW        = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N-1:0]      req_valid,
    input  logic [N*BITS-1:0] req_data,
    output logic [N-1:0]      req_ready,
    output logic              ser_load,
    output logic [BITS-1:0]   ser_word,
    output logic              ser_dk,
    output logic [IDW-1:0]    gnt_id
);

    localparam int unsigned BCW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int unsigned SCW = $clog2(SYNC_WORDS + 1);

    localparam logic [BCW-1:0] BitLast   = BCW'(BITS - 1);
    localparam logic [SCW-1:0] SyncFull  = SCW'(SYNC_WORDS);
    localparam logic [SCW-1:0] SyncAfter = SCW'(SYNC_WORDS - 1);

    typedef enum logic [1:0] {
        StSync,
        StRun,
        StPause
    } state_t;

    state_t         state;
    logic [BCW-1:0] bit_cnt;
    logic [SCW-1:0] sync_cnt;
    logic [IDW-1:0] last_gnt;

    logic            slot_end;
    logic            pick_valid;
    logic [IDW-1:0]  pick_idx;
    logic [BITS-1:0] pick_word;

    assign slot_end = (bit_cnt == BitLast);

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (k + 32'(last_gnt)) % N;
            if (!pick_valid && req_valid[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = IDW'(idx);
            end
        end
        pick_word = req_data[32'(pick_idx)*BITS +: BITS];
    end

    // Accept is offered only in the last clock of a RUN slot while the link is enabled.
    always_comb begin
        req_ready = '0;
        if (state == StRun && en && slot_end && pick_valid) begin
            req_ready[pick_idx] = 1'b1;
        end
    end

    // Slot sequencing, sync/pause control and the registered serializer outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= StSync;
            bit_cnt  <= BitLast;
            sync_cnt <= SyncFull;
            last_gnt <= IDW'(N - 1);
            ser_load <= 1'b0;
            ser_word <= '0;
            ser_dk   <= 1'b0;
            gnt_id   <= '0;
        end else begin
            ser_load <= 1'b0;
            case (state)
                StSync, StRun: begin
                    if (slot_end) begin
                        if (en) begin
                            bit_cnt  <= '0;
                            ser_load <= 1'b1;
                            if (state == StSync) begin
                                ser_word <= COMMA;
                                ser_dk   <= 1'b0;
                                sync_cnt <= sync_cnt - SCW'(1);
                                if (sync_cnt == SCW'(1)) begin
                                    state <= StRun;
                                end
                            end else if (pick_valid) begin
                                ser_word <= pick_word;
                                ser_dk   <= 1'b1;
                                gnt_id   <= pick_idx;
                                last_gnt <= pick_idx;
                            end else begin
                                ser_word <= IDLE_WORD;
                                ser_dk   <= 1'b0;
                            end
                        end else begin
                            // Counter parks at the last bit so resume is an immediate boundary.
                            state <= StPause;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BCW'(1);
                    end
                end
                StPause: begin
                    if (en) begin
                        bit_cnt  <= '0;
                        ser_load <= 1'b1;
                        ser_word <= COMMA;
                        ser_dk   <= 1'b0;
                        sync_cnt <= SyncAfter;
                        state    <= (SYNC_WORDS == 1) ? StRun : StSync;
                    end
                end
                default: begin
                    state <= StSync;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serdes_tx_sched.sv
// Directed bench for serdes_tx_sched: expected loads are queued with their cycle
// numbers as stimulus is applied and checked when the DUT strobes ser_load.
module tb_serdes_tx_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        ser_load;
    logic [7:0]  ser_word;
    logic        ser_dk;
    logic [1:0]  gnt_id;

    typedef struct {
        int         cyc;
        logic [7:0] word;
        logic       dk;
        logic [1:0] gnt;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   ntest = 0;
    int   nfail = 0;

    serdes_tx_sched dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .ser_load  (ser_load),
        .ser_word  (ser_word),
        .ser_dk    (ser_dk),
        .gnt_id    (gnt_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [7:0] w, input logic dk, input logic [1:0] g);
        exp_t e;
        e.cyc  = c;
        e.word = w;
        e.dk   = dk;
        e.gnt  = g;
        sb.push_back(e);
    endtask

    // One clock: sample just after the edge and score any load.
    task automatic clk1();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        if (ser_load) begin
            if (sb.size() == 0) begin
                chk("unexpected_load", 32'(ser_load), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("load_cycle", cyc, e.cyc);
                chk("ser_word", 32'(ser_word), 32'(e.word));
                chk("ser_dk", 32'(ser_dk), 32'(e.dk));
                if (e.dk) chk("gnt_id", 32'(gnt_id), 32'(e.gnt));
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            chk("missing_load", 32'(ser_load), 32'd1);
            void'(sb.pop_front());
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) clk1();
    endtask

    task automatic chk_rdy(input string tag, input logic [3:0] exp);
        #1;
        chk(tag, 32'(req_ready), 32'(exp));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_load"}, 32'(ser_load), 32'd0);
        chk({tag, "_word"}, 32'(ser_word), 32'd0);
        chk({tag, "_dk"}, 32'(ser_dk), 32'd0);
        chk({tag, "_gnt"}, 32'(gnt_id), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        req_valid = '0;
        req_data  = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");

        // Sync sequence then one idle word.
        push(1, 8'hBC, 1'b0, 2'd0);
        push(9, 8'hBC, 1'b0, 2'd0);
        push(17, 8'hBC, 1'b0, 2'd0);
        push(25, 8'hBC, 1'b0, 2'd0);
        push(33, 8'h1C, 1'b0, 2'd0);
        rst = 1'b1;
        wait_to(32);
        chk_rdy("rdy_no_valid", 4'b0000);
        wait_to(33);

        // All requesters busy: strict rotation starting at 0.
        req_data  = 32'hA3A2A1A0;
        req_valid = 4'b1111;
        push(41, 8'hA0, 1'b1, 2'd0);
        push(49, 8'hA1, 1'b1, 2'd1);
        push(57, 8'hA2, 1'b1, 2'd2);
        push(65, 8'hA3, 1'b1, 2'd3);
        push(73, 8'hA0, 1'b1, 2'd0);
        wait_to(40);  chk_rdy("rdy_rr0", 4'b0001);
        wait_to(44);  chk_rdy("rdy_midslot", 4'b0000);
        wait_to(48);  chk_rdy("rdy_rr1", 4'b0010);
        wait_to(56);  chk_rdy("rdy_rr2", 4'b0100);
        wait_to(64);  chk_rdy("rdy_rr3", 4'b1000);
        wait_to(72);  chk_rdy("rdy_rr4", 4'b0001);
        wait_to(73);

        // Single requester 2, then idle with gnt_id held.
        req_data[23:16] = 8'h5A;
        req_valid       = 4'b0100;
        push(81, 8'h5A, 1'b1, 2'd2);
        push(89, 8'h1C, 1'b0, 2'd0);
        wait_to(80);  chk_rdy("rdy_single2", 4'b0100);
        wait_to(81);  req_valid = 4'b0000;
        wait_to(88);  chk_rdy("rdy_dropped", 4'b0000);
        wait_to(89);
        chk("gnt_hold_idle", 32'(gnt_id), 32'd2);

        // Pause mid data slot, then resume through a fresh sync.
        req_valid = 4'b1000;
        push(97, 8'hA3, 1'b1, 2'd3);
        wait_to(96);  chk_rdy("rdy_req3", 4'b1000);
        wait_to(97);  req_valid = 4'b0000;
        wait_to(100);
        en        = 1'b0;
        req_valid = 4'b1111;
        wait_to(104); chk_rdy("rdy_en_off", 4'b0000);
        wait_to(120);
        chk("pause_word_hold", 32'(ser_word), 32'hA3);
        chk("pause_dk_hold", 32'(ser_dk), 32'd1);
        en = 1'b1;
        push(121, 8'hBC, 1'b0, 2'd0);
        push(129, 8'hBC, 1'b0, 2'd0);
        push(137, 8'hBC, 1'b0, 2'd0);
        push(145, 8'hBC, 1'b0, 2'd0);
        push(153, 8'hA0, 1'b1, 2'd0);
        wait_to(128); chk_rdy("rdy_in_sync", 4'b0000);
        wait_to(152); chk_rdy("rdy_resume", 4'b0001);
        wait_to(153); req_valid = 4'b0000;

        // Asynchronous reset in the middle of a slot.
        wait_to(158);
        req_valid = 4'b1111;
        rst       = 1'b0;
        #1;
        chk_zero_outputs("midslot_reset");
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("held_reset");
        req_valid = 4'b0000;
        cyc       = 0;
        push(1, 8'hBC, 1'b0, 2'd0);
        push(9, 8'hBC, 1'b0, 2'd0);
        push(17, 8'hBC, 1'b0, 2'd0);
        push(25, 8'hBC, 1'b0, 2'd0);
        rst = 1'b1;
        wait_to(25);

        // Requester 3 joins in a boundary cycle: order 1, 3, 1.
        req_data  = 32'h33001100;
        req_valid = 4'b0010;
        push(33, 8'h11, 1'b1, 2'd1);
        push(41, 8'h33, 1'b1, 2'd3);
        push(49, 8'h12, 1'b1, 2'd1);
        push(57, 8'h1C, 1'b0, 2'd0);
        wait_to(32);  chk_rdy("rdy_first1", 4'b0010);
        wait_to(33);  req_data[15:8] = 8'h12;
        wait_to(40);
        req_valid = 4'b1010;
        chk_rdy("rdy_late3", 4'b1000);
        wait_to(41);  req_valid = 4'b0010;
        wait_to(48);  chk_rdy("rdy_back1", 4'b0010);
        wait_to(49);  req_valid = 4'b0000;
        wait_to(56);  chk_rdy("rdy_final_idle", 4'b0000);
        wait_to(58);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
